player_input: RTL and testbench
===============================

// Module: player_input
//
// PURPOSE
//   Source of the L/R player-press pulses consumed by the tug-of-war light chain.
//   Converts two raw active-low push buttons into clean single-cycle press pulses:
//   - 2-flop synchroniser
//   - debounce counter
//   - rising-edge (press) detector
//   One pulse per physical press, no repeats while held. Sits between the board
//   KEYs and every light cell's L/R inputs.
//
// PARAMETERS
//   DEBOUNCE    4   cycles a synchronised level must stay stable before it is
//                   accepted; legal range >= 1
//   CPU_PERIOD  16  cycles between computer-player decisions (CPU_R_EN only); >= 2
//
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   KEY_L_n    in   1   raw left button, asynchronous, 0 = pressed
//   KEY_R_n    in   1   raw right button, asynchronous, 0 = pressed (ignored under CPU_R_EN)
//   cpu_level  in   9   computer-player aggressiveness; port exists only under CPU_R_EN
//   L          out  1   one-cycle left-press pulse, registered
//   R          out  1   one-cycle right-press pulse, registered
//
// BEHAVIOUR
//   Clocking and reset
//   - All state updates on posedge clk only. Reset is synchronous, active-high.
//   - Reset values:
//     - sync flops = released
//     - debounced state = released
//     - debounce counters = 0
//     - L = 0, R = 0
//     - LFSR = 10'h000, period counter = 0
//
//   Per-channel datapath (L and R identical, fully independent)
//   - press_raw = ~KEY_x_n, passed through s0 -> s1.
//   - deb   : accepted level.
//   - cnt   : debounce counter, width $clog2(DEBOUNCE+1).
//   - If s1 == deb: cnt <= 0.
//   - Else if cnt == DEBOUNCE-1: deb <= s1 and cnt <= 0.
//   - Else: cnt <= cnt+1.
//   - Output pulse: L <= (deb == 0) && (deb_next == 1). The pulse register updates
//     on the same edge deb rises, so it is high for exactly one cycle.
//
//   Latency
//   - Raw press stable before edge 1 -> pulse high after edge DEBOUNCE+2,
//     low again after edge DEBOUNCE+3.
//
//   Boundary conditions
//   - Held button: a single pulse only.
//   - Release: debounced the same way; produces no pulse.
//   - Glitch shorter than DEBOUNCE synchronised cycles: cnt is cleared, no pulse.
//   - Simultaneous L and R presses: both pulses may assert in the same cycle.
//     No arbitration here; the light cells treat L&R as no move.
//   - Reset mid-debounce or mid-pulse: everything cleared, pending press is
//     discarded.
//   - Button held through reset: after reset deasserts it is seen as a new press
//     and pulses DEBOUNCE+2 cycles later.
//
// CONFIGURATION
//   CPU_R_EN defined
//   - KEY_R_n and the right debouncer are unused; R is driven by a computer player.
//   - Adds the cpu_level input port.
//   - 10-bit LFSR, XNOR feedback, taps 10 and 7 (bit0_next = q[9] ~^ q[6]),
//     shifts left every cycle.
//   - Period counter counts 0..CPU_PERIOD-1 and wraps.
//   - On the wrap cycle: R <= (lfsr < {1'b0, cpu_level}).
//   - All other cycles: R <= 0.
//   - Consequences:
//     - cpu_level = 0 never presses.
//     - Maximum rate is one pulse per CPU_PERIOD cycles.
//   CPU_R_EN undefined
//   - Two identical human channels as described above.
//   - No cpu_level port, no LFSR logic.
//
// TESTING
//   1. DEBOUNCE=4: KEY_L_n 1->0 held 20 cycles
//      -> exactly one L pulse, high during cycle 6 after the drop; R stays 0.
//   2. KEY_L_n low for 3 cycles then high (glitch)
//      -> L never asserts; a later 10-cycle press pulses once.
//   3. KEY_L_n and KEY_R_n dropped on the same edge
//      -> L and R pulse on the same cycle, once each.
//   4. Press, reset asserted 4 cycles after the drop for 2 cycles, key kept held
//      -> no pulse before reset; one pulse 6 cycles after reset drops.
//   5. Press, release, wait 10 cycles, press again
//      -> two separate L pulses; no pulse on the release.
//   6. CPU_R_EN, CPU_PERIOD=16:
//      - cpu_level=0 for 2000 cycles -> R stays 0.
//      - cpu_level=511 -> every R pulse aligns with a period wrap, gaps are
//        multiples of 16, and the pulse count matches a reference-model LFSR.

Source files
------------

// File: rtl/player_input.sv
// Debounced one-shot press pulses for the two tug-of-war players.
// Define CPU_R_EN to replace the right button with an LFSR computer player.
module player_input #(
  parameter int DEBOUNCE   = 4,
  parameter int CPU_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KEY_L_n,
  input  logic       KEY_R_n,
`ifdef CPU_R_EN
  input  logic [8:0] cpu_level,
`endif
  output logic       L,
  output logic       R
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

`ifdef CPU_R_EN
  localparam int NCH = 1;
`else
  localparam int NCH = 2;
`endif

  if (DEBOUNCE < 1 || CPU_PERIOD < 2) begin : g_bad_param
    $error("player_input: illegal parameter value");
  end

  logic [NCH-1:0] press_raw;

  logic [NCH-1:0] s0_q;
  logic [NCH-1:0] s0_d;
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s1_d;
  logic [NCH-1:0] deb_q;
  logic [NCH-1:0] deb_d;
  logic [NCH-1:0] pls_q;
  logic [NCH-1:0] pls_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

`ifdef CPU_R_EN
  localparam int PW = $clog2(CPU_PERIOD);
  localparam logic [PW-1:0] PC_LAST = PW'(CPU_PERIOD - 1);

  logic          unused_key_r;
  logic [9:0]    lfsr_q;
  logic [9:0]    lfsr_d;
  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;
  logic          r_q;
  logic          r_d;
  logic          wrap;

  assign unused_key_r = KEY_R_n;
  assign press_raw    = ~KEY_L_n;
`else
  assign press_raw = {~KEY_R_n, ~KEY_L_n};
`endif

  // A run of s1 != deb must reach DEBOUNCE edges to flip the level.
  always_comb begin
    s0_d  = press_raw;
    s1_d  = s0_q;
    deb_d = deb_q;
    pls_d = '0;
    cnt_d = '{default: '0};
    for (int i = 0; i < NCH; i++) begin
      if (s1_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      pls_d[i] = !deb_q[i] && deb_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q  <= '0;
      s1_q  <= '0;
      deb_q <= '0;
      pls_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      deb_q <= deb_d;
      pls_q <= pls_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef CPU_R_EN
  assign wrap = (pc_q == PC_LAST);

  always_comb begin
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ~^ lfsr_q[6]};
    pc_d   = wrap ? '0 : pc_q + PW'(1);
    r_d    = wrap && (lfsr_q < {1'b0, cpu_level});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= '0;
      pc_q   <= '0;
      r_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      pc_q   <= pc_d;
      r_q    <= r_d;
    end
  end

  assign L = pls_q[0];
  assign R = r_q;
`else
  assign L = pls_q[0];
  assign R = pls_q[1];
`endif

endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: vector table, corner sequences, random vs model.
module tb_player_input;

  localparam int D = 4;
  localparam int P = 16;

  logic clk = 1'b0;
  logic reset;
  logic key_l_n;
  logic key_r_n;
  logic l;
  logic r;
`ifdef CPU_R_EN
  logic [8:0] cpu_level;
`endif

  always #5 clk = ~clk;

  player_input #(
    .DEBOUNCE  (D),
    .CPU_PERIOD(P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .KEY_L_n  (key_l_n),
    .KEY_R_n  (key_r_n),
`ifdef CPU_R_EN
    .cpu_level(cpu_level),
`endif
    .L        (l),
    .R        (r)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a press is accepted once the level seen two
  // cycles late has sat opposite the accepted level for D edges.
  bit       hq [2][$];
  bit       mdeb [2];
  bit       mpls [2];
  bit [9:0] mlfsr;
  int       mcyc;
  bit       mr;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      hq[c].delete();
      repeat (D + 2) hq[c].push_back(1'b0);
      mdeb[c] = 1'b0;
      mpls[c] = 1'b0;
    end
    mlfsr = '0;
    mcyc  = 0;
    mr    = 1'b0;
  endtask

  task automatic model_step(bit kl_n, bit kr_n);
    bit [1:0] press;
    bit all_opp;
    press = {~kr_n, ~kl_n};
    for (int c = 0; c < 2; c++) begin
      hq[c].push_back(press[c]);
      void'(hq[c].pop_front());
      all_opp = 1'b1;
      for (int j = 0; j < D; j++)
        if (hq[c][j] == mdeb[c]) all_opp = 1'b0;
      mpls[c] = 1'b0;
      if (all_opp) begin
        mdeb[c] = ~mdeb[c];
        mpls[c] = mdeb[c];
      end
    end
`ifdef CPU_R_EN
    mr = (mcyc % P == P - 1) &&
         (int'(mlfsr) < int'(cpu_level));
`endif
    mlfsr = {mlfsr[8:0], ~(mlfsr[9] ^ mlfsr[6])};
    mcyc++;
  endtask

  task automatic cyc(bit rst, bit kl_n, bit kr_n);
    reset   = rst;
    key_l_n = kl_n;
    key_r_n = kr_n;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step(kl_n, kr_n);
  endtask

  task automatic chk(string name, bit el, bit er);
`ifdef CPU_R_EN
    er = mr;
`endif
    n_vec++;
    if (l !== el || r !== er) begin
      n_err++;
      $display("FAIL %s @%0t: L=%b R=%b, expected L=%b R=%b",
               name, $time, l, r, el, er);
    end
  endtask

  typedef struct {
    bit    rst;
    bit    kl_n;
    bit    kr_n;
    bit    el;
    bit    er;
    string name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit kl_n, bit kr_n,
                              bit el, bit er, string name);
    vec_t v;
    v.rst  = rst;
    v.kl_n = kl_n;
    v.kr_n = kr_n;
    v.el   = el;
    v.er   = er;
    v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    bit lv;
    bit rv;
    int lrun;
    int rrun;
    int last;
    int dut_cnt;
    int mdl_cnt;

    reset   = 1'b1;
    key_l_n = 1'b1;
    key_r_n = 1'b1;
`ifdef CPU_R_EN
    cpu_level = '0;
`endif
    model_reset();

    repeat (2) add(1, 1, 1, 0, 0, "reset");
    repeat (3) add(0, 1, 1, 0, 0, "idle");
    for (int i = 1; i <= 20; i++) add(0, 0, 1, i == 6, 0, "held_l");
    repeat (10) add(0, 1, 1, 0, 0, "release_l");
    repeat (3) add(0, 0, 1, 0, 0, "glitch");
    repeat (10) add(0, 1, 1, 0, 0, "glitch_end");
    for (int i = 1; i <= 10; i++)
      add(0, 0, 1, i == 6, 0, "press_after_glitch");
    repeat (10) add(0, 1, 1, 0, 0, "release_l2");
    for (int i = 1; i <= 12; i++)
      add(0, 0, 0, i == 6, i == 6, "both");
    repeat (10) add(0, 1, 1, 0, 0, "release_both");

    foreach (tbl[k]) begin
      cyc(tbl[k].rst, tbl[k].kl_n, tbl[k].kr_n);
      chk(tbl[k].name, tbl[k].el, tbl[k].er);
    end

    // Reset in mid-debounce while the key stays held.
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1);
      chk("pre_reset", 0, 0);
    end
    repeat (2) begin
      cyc(1, 0, 1);
      chk("in_reset", 0, 0);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1);
      chk("post_reset", i == 6, 0);
    end
    repeat (10) begin
      cyc(0, 1, 1);
      chk("post_reset_rel", 0, 0);
    end

    // Press, release, pause, press again.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 1; i <= 10; i++) begin
        cyc(0, 0, 1);
        chk("repress", i == 6, 0);
      end
      repeat (10) begin
        cyc(0, 1, 1);
        chk("repress_rel", 0, 0);
      end
    end

    // Random run lengths straddling the debounce window.
    lv = 1'b1;
    rv = 1'b1;
    lrun = 1;
    rrun = 1;
    for (int i = 0; i < 4000; i++) begin
      if (--lrun == 0) begin
        lv = ~lv;
        lrun = $urandom_range(1, 3 * D);
      end
      if (--rrun == 0) begin
        rv = ~rv;
        rrun = $urandom_range(1, 3 * D);
      end
`ifdef CPU_R_EN
      if (i % 500 == 0) cpu_level = 9'($urandom);
`endif
      cyc($urandom_range(0, 299) == 0, lv, rv);
      chk("random", mpls[0], mpls[1]);
    end

`ifdef CPU_R_EN
    cpu_level = '0;
    cyc(1, 1, 1);
    chk("cpu_reset", 0, 0);
    for (int i = 0; i < 2000; i++) begin
      cyc(0, 1, 1);
      chk("cpu_level0", 0, 0);
      n_vec++;
      if (r !== 1'b0) begin
        n_err++;
        $display("FAIL cpu_level0_r: R=%b, expected 0", r);
      end
    end

    cpu_level = 9'd511;
    cyc(1, 1, 1);
    chk("cpu_reset2", 0, 0);
    last = -1;
    dut_cnt = 0;
    mdl_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(0, 1, 1);
      chk("cpu_level511", 0, 0);
      if (mr) mdl_cnt++;
      if (r === 1'b1) begin
        dut_cnt++;
        n_vec++;
        if (mcyc % P != 0 ||
            (last >= 0 && (mcyc - last) % P != 0)) begin
          n_err++;
          $display("FAIL cpu_align: pulse at cycle %0d, expected multiple of %0d",
                   mcyc, P);
        end
        last = mcyc;
      end
    end
    n_vec++;
    if (dut_cnt != mdl_cnt || mdl_cnt == 0) begin
      n_err++;
      $display("FAIL cpu_count: got %0d pulses, expected %0d",
               dut_cnt, mdl_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
